// File: rtl/spi_cmd_receiver.sv
// Oversampled SPI mode-0 slave: deserialises WORD_WIDTH-bit command words and presents each with a held strobe.
// Optional feature: define SPI_ECHO_EN to echo the last accepted word back on MISO.
module spi_cmd_receiver #(
    parameter int unsigned WORD_WIDTH    = 32,
    parameter int unsigned STROBE_CYCLES = 4,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  spi_miso_oeb,
    output logic [WORD_WIDTH-1:0] spi_data,
    output logic                  spi_data_clock,
    output logic                  frame_error,
    output logic [7:0]            overrun_count
);

    localparam int unsigned CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned STB_W = $clog2(STROBE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
    localparam logic [STB_W-1:0] STB_LOAD = STB_W'(STROBE_CYCLES);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]  shift_q, shift_d;
    logic [STB_W-1:0]       strobe_cnt_q, strobe_cnt_d;
    logic [WORD_WIDTH-1:0]  data_q, data_d;
    logic                   data_clock_q, data_clock_d;
    logic                   frame_error_q, frame_error_d;
    logic [7:0]             overrun_q, overrun_d;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, cs_fall, cs_rise;
    logic word_done;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // The state register doubles as the edge-detect flop for chip select.
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign cs_fall   = (state_q == IDLE) & ~cs_s;
    assign cs_rise   = (state_q == SHIFT) & cs_s;

`ifdef SPI_ECHO_EN
    logic [WORD_WIDTH-1:0] echo_q, echo_d;
    logic                  skip_q, skip_d;
    logic                  sclk_fall;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        sclk_prev_d = sclk_s;
        state_d     = cs_s ? IDLE : SHIFT;

        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        word_done     = 1'b0;
        frame_error_d = 1'b0;

        // Frame start clears first so a coincident SCLK rise lands as bit 0.
        if (cs_fall) begin
            bit_cnt_d = '0;
            shift_d   = '0;
        end
        if (!cs_s && sclk_rise) begin
            shift_d = {shift_d[WORD_WIDTH-2:0], mosi_s};
            if (bit_cnt_d == LAST_BIT) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_d + CNT_W'(1);
            end
        end
        if (cs_rise) begin
            frame_error_d = (bit_cnt_q != '0);
            bit_cnt_d     = '0;
            shift_d       = '0;
        end

        strobe_cnt_d = (strobe_cnt_q != '0) ? strobe_cnt_q - STB_W'(1) : '0;
        data_d       = data_q;
        overrun_d    = overrun_q;
        if (word_done) begin
            if (strobe_cnt_q == '0) begin
                data_d       = shift_d;
                strobe_cnt_d = STB_LOAD;
            end else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end
        data_clock_d = (strobe_cnt_d != '0);

`ifdef SPI_ECHO_EN
        echo_d = echo_q;
        skip_d = skip_q;
        if (cs_fall) begin
            echo_d = data_q;
            skip_d = 1'b0;
        end
        // The SCLK fall right after a reload must not consume the fresh MSB.
        if (!cs_s && sclk_fall) begin
            if (skip_q) begin
                skip_d = 1'b0;
            end else begin
                echo_d = {echo_q[WORD_WIDTH-2:0], 1'b0};
            end
        end
        if (word_done) begin
            echo_d = data_d;
            skip_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync_q   <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sclk_prev_q   <= 1'b0;
            state_q       <= IDLE;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            strobe_cnt_q  <= '0;
            data_q        <= '0;
            data_clock_q  <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= '0;
`ifdef SPI_ECHO_EN
            echo_q        <= '0;
            skip_q        <= 1'b0;
`endif
        end else begin
            sclk_sync_q   <= sclk_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            state_q       <= state_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            strobe_cnt_q  <= strobe_cnt_d;
            data_q        <= data_d;
            data_clock_q  <= data_clock_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
`ifdef SPI_ECHO_EN
            echo_q        <= echo_d;
            skip_q        <= skip_d;
`endif
        end
    end

    assign spi_data       = data_q;
    assign spi_data_clock = data_clock_q;
    assign frame_error    = frame_error_q;
    assign overrun_count  = overrun_q;

`ifdef SPI_ECHO_EN
    assign spi_miso     = echo_q[WORD_WIDTH-1];
    assign spi_miso_oeb = cs_s;
`else
    assign spi_miso     = 1'b0;
    assign spi_miso_oeb = 1'b1;
`endif

endmodule
